scoreboard_mux_display: RTL and testbench

//  Successor to the fixed 4-digit win/lose display: holds two decimal scores (win, lose)
//  as internal BCD counters and drives an N-digit multiplexed common-anode 7-seg display.

---
 rtl/scoreboard_mux_display_if.sv | 25 ++
 rtl/scoreboard_mux_display.sv | 172 +++++++++++++++++
 tb/tb_scoreboard_mux_display.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/scoreboard_mux_display_if.sv
// Game-event inputs and multiplexed 7-seg display pins of the scoreboard.
// Latency: none (bundle of wires only).
// Backpressure: none; event inputs are level signals, display outputs are free-running.
interface scoreboard_mux_display_if #(
  parameter int N_DIGITS = 4
);
  logic                win_inc;
  logic                lose_inc;
  logic                clr;
  logic [6:0]          seg;
  logic [N_DIGITS-1:0] an;
  logic                dp;

  // Stimulus / board side: drives events, observes the display
  modport master (
    output win_inc, lose_inc, clr,
    input  seg, an, dp
  );

  // Scoreboard side: consumes events, drives the display
  modport slave (
    input  win_inc, lose_inc, clr,
    output seg, an, dp
  );
endinterface

// File: rtl/scoreboard_mux_display.sv
// Two BCD scores (win/lose) shown on an N-digit multiplexed common-anode 7-seg display.
// Latency: score updates on the input rising edge; seg/an/dp follow sel one cycle later.
// Backpressure: none; each rising edge of win_inc/lose_inc counts once, saturating at all 9s.
// Optional macro SCOREBOARD_BLINK_EN: blink saturated sides every 256 refresh ticks.
module scoreboard_mux_display #(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  scoreboard_mux_display_if.slave bus
);

  localparam int H       = N_DIGITS / 2;
  localparam int SW      = $clog2(N_DIGITS);
  localparam int PW      = (PRESCALE_W > 0) ? PRESCALE_W : 1;
  localparam int SCORE_W = 4 * H;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {H{4'h9}};

  logic [SCORE_W-1:0]    win_score, lose_score;
  logic                  win_q, lose_q;
  logic                  win_rise, lose_rise;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [SW-1:0]         sel;
  logic [N_DIGITS-1:0]   blank;
  logic [N_DIGITS-1:0]   blink_force;
  logic [4*N_DIGITS-1:0] digits;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            seg_nxt;
  logic [N_DIGITS-1:0]   an_nxt;
  logic                  dp_nxt;

  // BCD +1 with ripple carry; a score already at all 9s is held
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = (v != SCORE_MAX);
    for (int i = 0; i < H; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low gfedcba segment pattern for one BCD digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign win_rise  = bus.win_inc  & ~win_q;
  assign lose_rise = bus.lose_inc & ~lose_q;

  // Edge registers always track the inputs; clr wins over increments
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      win_score  <= '0;
      lose_score <= '0;
    end else begin
      win_q  <= bus.win_inc;
      lose_q <= bus.lose_inc;
      if (bus.clr) begin
        win_score  <= '0;
        lose_score <= '0;
      end else begin
        if (win_rise)  win_score  <= bcd_inc(win_score);
        if (lose_rise) lose_score <= bcd_inc(lose_score);
      end
    end
  end

  // With a zero-width prescaler every cycle is a refresh tick
  assign tick = (PRESCALE_W == 0) || (&presc);

  // Free-running prescaler and digit select
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc <= '0;
      sel   <= '0;
    end else begin
      if (PRESCALE_W != 0) presc <= presc + PW'(1);
      if (tick) sel <= (sel == SW'(N_DIGITS - 1)) ? '0 : sel + SW'(1);
    end
  end

`ifdef SCOREBOARD_BLINK_EN
  logic [7:0] blink_cnt;
  logic       blink_ph;
  logic       win_sat, lose_sat;

  assign win_sat  = (win_score  == SCORE_MAX);
  assign lose_sat = (lose_score == SCORE_MAX);

  // Blink phase flips after every 256 refresh ticks; clr restarts it dark-free
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (tick) begin
      blink_cnt <= blink_cnt + 8'd1;
      if (&blink_cnt) blink_ph <= ~blink_ph;
    end
  end

  assign blink_force = blink_ph ? {{H{win_sat}}, {H{lose_sat}}} : '0;
`else
  assign blink_force = '0;
`endif

  // Leading-zero blanking per side, scanning down from each side's top digit
  always_comb begin
    logic zl, zw;
    blank  = '0;
    zl     = 1'b1;
    zw     = 1'b1;
    for (int i = H - 1; i >= 1; i--) begin
      zl           = zl && (lose_score[4*i +: 4] == 4'd0);
      zw           = zw && (win_score[4*i +: 4]  == 4'd0);
      blank[i]     = zl;
      blank[H + i] = zw;
    end
    blank = blank | blink_force;
  end

  assign digits    = {win_score, lose_score};
  assign cur_digit = digits[{sel, 2'b00} +: 4];
  assign cur_blank = blank[sel];

  // Display pattern for the currently selected slot
  always_comb begin
    seg_nxt      = cur_blank ? 7'h7F : seg_decode(cur_digit);
    an_nxt       = '1;
    if (!cur_blank) an_nxt[sel] = 1'b0;
    dp_nxt       = !((sel == SW'(H)) && !cur_blank);
  end

  // Registered pins; dark while in reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.seg <= 7'h7F;
      bus.an  <= '1;
      bus.dp  <= 1'b1;
    end else begin
      bus.seg <= seg_nxt;
      bus.an  <= an_nxt;
      bus.dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_scoreboard_mux_display.sv
// Directed bench for scoreboard_mux_display with N_DIGITS=4, PRESCALE_W=2.
// Latency: display slot k shown from posedge 4k+1 to 4k+4 after reset release.
// Backpressure: none; events applied as one-cycle pulses or held levels.
module tb_scoreboard_mux_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  scoreboard_mux_display_if #(.N_DIGITS(4)) bus();

  scoreboard_mux_display #(.N_DIGITS(4), .PRESCALE_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Posedges since reset release; gives the expected scan slot
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  typedef struct {
    bit         do_clr;
    int         win_p;
    int         lose_p;
    logic [6:0] s0, s1, s2, s3;
    logic [3:0] blank;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [3:0] e_an,
                       input logic [6:0] e_seg, input logic e_dp);
    checks++;
    if (bus.an === e_an && bus.seg === e_seg && bus.dp === e_dp) begin
      passed++;
    end else begin
      $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
    end
  endtask

  task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] blank);
    logic [6:0] es[4];
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         slot;
    es  = '{s0, s1, s2, s3};
    one = 4'b0001;
    repeat (16) begin
      @(negedge clk);
      if (cyc > 0 && ((cyc - 1) % 4) == 3) begin
        slot  = ((cyc - 1) / 4) % 4;
        e_an  = blank[slot] ? 4'hF : ~(one << slot);
        e_seg = blank[slot] ? 7'h7F : es[slot];
        e_dp  = !(slot == 2 && !blank[slot]);
        check($sformatf("%s slot%0d", name, slot), e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle pulses; overlapping indices rise on the same edge
  task automatic pulses(input int w, input int l);
    int m;
    m = (w > l) ? w : l;
    for (int i = 0; i < m; i++) begin
      bus.win_inc  = (i < w);
      bus.lose_inc = (i < l);
      @(negedge clk);
      bus.win_inc  = 1'b0;
      bus.lose_inc = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    // Cumulative score scenarios with hand-decoded digits
    vecs[0] = '{0, 0,   0,   7'b1000000, 7'h7F,      7'b1000000, 7'h7F,      4'b1010};
    vecs[1] = '{0, 3,   12,  7'b0100100, 7'b1111001, 7'b0110000, 7'h7F,      4'b1000};
    vecs[2] = '{0, 7,   0,   7'b0100100, 7'b1111001, 7'b1000000, 7'b1111001, 4'b0000};
    vecs[3] = '{1, 5,   0,   7'b1000000, 7'h7F,      7'b0010010, 7'h7F,      4'b1010};
    vecs[4] = '{1, 0,   105, 7'b0010000, 7'b0010000, 7'b1000000, 7'h7F,      4'b1000};
    vecs[5] = '{0, 104, 0,   7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000, 4'b0000};
    vecs[6] = '{1, 8,   40,  7'b1000000, 7'b0011001, 7'b0000000, 7'h7F,      4'b1000};
    vecs[7] = '{0, 0,   27,  7'b1111000, 7'b0000010, 7'b0000000, 7'h7F,      4'b1000};

    bus.win_inc  = 1'b0;
    bus.lose_inc = 1'b0;
    bus.clr      = 1'b0;

    // Held reset keeps the display dark
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset cycle %0d", i), 4'hF, 7'h7F, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("first slot after reset", 4'b1110, 7'b1000000, 1'b1);

    // Free-running scan with both scores zero
    check_frame("scan zero", 7'b1000000, 7'h7F, 7'b1000000, 7'h7F, 4'b1010);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].do_clr) begin
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
      end
      pulses(vecs[v].win_p, vecs[v].lose_p);
      idle(2);
      check_frame($sformatf("vec%0d", v), vecs[v].s0, vecs[v].s1, vecs[v].s2,
                  vecs[v].s3, vecs[v].blank);
    end

    // Held-high input counts once
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr     = 1'b0;
    bus.win_inc = 1'b1;
    idle(20);
    bus.win_inc = 1'b0;
    idle(2);
    check_frame("win held", 7'b1000000, 7'h7F, 7'b1111001, 7'h7F, 4'b1010);

    // Simultaneous rising edges both count: win 02, lose 01
    pulses(1, 1);
    idle(2);
    check_frame("both rise", 7'b1111001, 7'h7F, 7'b0100100, 7'h7F, 4'b1010);

    // clr beats edges; inputs still high after clr give no new edge
    bus.clr      = 1'b1;
    bus.win_inc  = 1'b1;
    bus.lose_inc = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    idle(3);
    bus.win_inc  = 1'b0;
    bus.lose_inc = 1'b0;
    idle(2);
    check_frame("clr with edges", 7'b1000000, 7'h7F, 7'b1000000, 7'h7F, 4'b1010);

    // Reset in the middle of a scan
    pulses(3, 0);
    idle(5);
    rst = 1'b0;
    @(negedge clk);
    check("mid-scan reset dark", 4'hF, 7'h7F, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-scan resume slot0", 4'b1110, 7'b1000000, 1'b1);
    check_frame("after mid reset", 7'b1000000, 7'h7F, 7'b1000000, 7'h7F, 4'b1010);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
